// File: rtl/sad_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sad_ctrl
// Summary  : Controller for a sum-of-absolute-differences datapath. It issues
//            the block reads and the accumulator clear/load/store strobes.
//            Build option SAD_CTRL_ABORT_EN adds the abort/aborted ports.
// Revision : 1.0 - initial release
// ============================================================================
module sad_ctrl #(
  parameter int BLOCK_SIZE = 256,
  parameter int ADDR_W     = 8
) (
  input  logic              clk,
  input  logic              Mrst,
`ifdef SAD_CTRL_ABORT_EN
  input  logic              abort,
  output logic              aborted,
`endif
  input  logic              go,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] addr,
  output logic              sum_clr,
  output logic              sum_ld,
  output logic              sadreg_ld,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(BLOCK_SIZE - 1);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    INIT  = 3'd1,
    READ  = 3'd2,
    DRAIN = 3'd3,
    STORE = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t state;

  // Outputs are registered from the next state, so each state's strobes are
  // valid for exactly the cycles that state occupies.
  always_ff @(posedge clk or posedge Mrst) begin
    if (Mrst) begin
      state     <= IDLE;
      mem_rd    <= 1'b0;
      addr      <= '0;
      sum_clr   <= 1'b0;
      sum_ld    <= 1'b0;
      sadreg_ld <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
`ifdef SAD_CTRL_ABORT_EN
      aborted   <= 1'b0;
`endif
    end else begin
      sum_clr   <= 1'b0;
      sadreg_ld <= 1'b0;
      done      <= 1'b0;
      // Read data arrives one cycle after the strobe.
      sum_ld    <= mem_rd;
`ifdef SAD_CTRL_ABORT_EN
      aborted   <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (go) begin
            state   <= INIT;
            sum_clr <= 1'b1;
            busy    <= 1'b1;
            addr    <= '0;
          end
        end
        INIT: begin
          state  <= READ;
          mem_rd <= 1'b1;
          addr   <= '0;
        end
        READ: begin
          if (addr == LAST_ADDR) begin
            state  <= DRAIN;
            mem_rd <= 1'b0;
            addr   <= '0;
          end else begin
            addr <= addr + ADDR_W'(1);
          end
        end
        DRAIN: begin
          state     <= STORE;
          sadreg_ld <= 1'b1;
        end
        STORE: begin
          state <= DONE;
          done  <= 1'b1;
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state  <= IDLE;
          mem_rd <= 1'b0;
          addr   <= '0;
          busy   <= 1'b0;
        end
      endcase
`ifdef SAD_CTRL_ABORT_EN
      // Abort overrides the normal transition only while the block is in flight.
      if (abort && (state == INIT || state == READ || state == DRAIN)) begin
        state     <= IDLE;
        mem_rd    <= 1'b0;
        addr      <= '0;
        sum_clr   <= 1'b0;
        sum_ld    <= 1'b0;
        sadreg_ld <= 1'b0;
        busy      <= 1'b0;
        done      <= 1'b0;
        aborted   <= 1'b1;
      end
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sad_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_sad_ctrl
// Summary  : Directed self-checking bench for sad_ctrl (BLOCK_SIZE 4 and 256).
// Revision : 1.0 - initial release
// ============================================================================
module tb_sad_ctrl;

  logic       clk = 1'b0;
  logic       Mrst, go, go_big;
  logic       mem_rd, sum_clr, sum_ld, sadreg_ld, busy, done;
  logic [7:0] addr;
  logic       b_mem_rd, b_sum_clr, b_sum_ld, b_sadreg_ld, b_busy, b_done;
  logic [7:0] b_addr;
`ifdef SAD_CTRL_ABORT_EN
  logic       abort, aborted, b_aborted;
`endif

  int n_checks = 0;
  int n_pass   = 0;
  int viol     = 0;

  always #5 clk = ~clk;

  sad_ctrl #(.BLOCK_SIZE(4), .ADDR_W(8)) u_dut (
    .clk(clk), .Mrst(Mrst),
`ifdef SAD_CTRL_ABORT_EN
    .abort(abort), .aborted(aborted),
`endif
    .go(go), .mem_rd(mem_rd), .addr(addr), .sum_clr(sum_clr), .sum_ld(sum_ld),
    .sadreg_ld(sadreg_ld), .busy(busy), .done(done)
  );

  sad_ctrl u_big (
    .clk(clk), .Mrst(Mrst),
`ifdef SAD_CTRL_ABORT_EN
    .abort(1'b0), .aborted(b_aborted),
`endif
    .go(go_big), .mem_rd(b_mem_rd), .addr(b_addr), .sum_clr(b_sum_clr),
    .sum_ld(b_sum_ld), .sadreg_ld(b_sadreg_ld), .busy(b_busy), .done(b_done)
  );

  // Strobe exclusivity and addr-zero-outside-READ, on the small instance.
  always @(negedge clk) begin
    if (Mrst === 1'b0) begin
      if ((int'(mem_rd) + int'(sum_clr) + int'(sadreg_ld) + int'(done) > 1) ||
          (sum_ld && (sum_clr || sadreg_ld || done)) ||
          (!mem_rd && addr != 8'd0))
        viol++;
    end
  end

  function automatic logic [13:0] outs();
    return {mem_rd, sum_clr, sum_ld, sadreg_ld, done, busy, addr};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    Mrst = 1'b1; go = 1'b0; go_big = 1'b0;
`ifdef SAD_CTRL_ABORT_EN
    abort = 1'b0;
`endif
    step(); step();
    n_checks++;
    if (outs() !== 14'd0) $display("FAIL reset_outputs: got %h expected 0000", outs());
    else n_pass++;
    Mrst = 1'b0;
    step();
    n_checks++;
    if (outs() !== 14'd0) $display("FAIL idle_after_reset: got %h expected 0000", outs());
    else n_pass++;
  endtask

  task automatic test_basic();
    logic [13:0] exp [1:9];
    exp[1] = {6'b010001, 8'd0};
    exp[2] = {6'b100001, 8'd0};
    exp[3] = {6'b101001, 8'd1};
    exp[4] = {6'b101001, 8'd2};
    exp[5] = {6'b101001, 8'd3};
    exp[6] = {6'b001001, 8'd0};
    exp[7] = {6'b000101, 8'd0};
    exp[8] = {6'b000011, 8'd0};
    exp[9] = {6'b000000, 8'd0};
    go = 1'b1;
    step();
    go = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      if (c > 1) step();
      n_checks++;
      if (outs() !== exp[c])
        $display("FAIL basic_cycle%0d: got %h expected %h", c, outs(), exp[c]);
      else n_pass++;
    end
  endtask

  task automatic test_back_to_back();
    int dc [3];
    int nd = 0;
    go = 1'b1;
    for (int c = 1; c <= 40 && nd < 3; c++) begin
      step();
      if (done) begin
        dc[nd] = c;
        nd++;
        if (nd == 3) go = 1'b0;
      end
    end
    go = 1'b0;
    n_checks++;
    if (nd !== 3) $display("FAIL b2b_count: got %0d expected 3", nd);
    else n_pass++;
    if (nd == 3) begin
      n_checks++;
      if (dc[0] !== 8) $display("FAIL b2b_first: got %0d expected 8", dc[0]);
      else n_pass++;
      n_checks++;
      if (dc[1] - dc[0] !== 9 || dc[2] - dc[1] !== 9)
        $display("FAIL b2b_spacing: got %0d,%0d expected 9,9", dc[1] - dc[0], dc[2] - dc[1]);
      else n_pass++;
    end
    step(); step(); step();
    n_checks++;
    if (busy !== 1'b0) $display("FAIL b2b_stop: busy got %b expected 0", busy);
    else n_pass++;
  endtask

  task automatic test_go_during_read();
    int nd = 0;
    int first = 0;
    go = 1'b1; step(); go = 1'b0;
    step(); step();
    go = 1'b1; step(); go = 1'b0;
    for (int c = 5; c <= 24; c++) begin
      step();
      if (done) begin
        nd++;
        if (first == 0) first = c;
      end
    end
    n_checks++;
    if (nd !== 1 || first !== 8)
      $display("FAIL go_in_read: got %0d runs done@%0d expected 1 run done@8", nd, first);
    else n_pass++;
  endtask

  task automatic test_mid_reset();
    int bad = 0;
    int dc = 0;
    int nld = 0;
    go = 1'b1; step(); go = 1'b0;
    step(); step(); step();
    n_checks++;
    if (addr !== 8'd2) $display("FAIL midrst_addr: got %0d expected 2", addr);
    else n_pass++;
    #2 Mrst = 1'b1;
    #1;
    n_checks++;
    if (outs() !== 14'd0) $display("FAIL midrst_async: got %h expected 0000", outs());
    else n_pass++;
    step();
    Mrst = 1'b0;
    for (int c = 0; c < 12; c++) begin
      step();
      if (sadreg_ld || done || busy) bad++;
    end
    n_checks++;
    if (bad !== 0) $display("FAIL midrst_quiet: got %0d active cycles expected 0", bad);
    else n_pass++;
    go = 1'b1; step(); go = 1'b0;
    for (int c = 1; c <= 20 && dc == 0; c++) begin
      if (c > 1) step();
      if (sum_ld) nld++;
      if (done) dc = c;
    end
    n_checks++;
    if (dc !== 8 || nld !== 4)
      $display("FAIL midrst_rerun: got done@%0d ld=%0d expected done@8 ld=4", dc, nld);
    else n_pass++;
  endtask

  task automatic test_default_size();
    int dc = 0;
    int nld = 0;
    int nrd = 0;
    int amax = 0;
    go_big = 1'b1; step(); go_big = 1'b0;
    for (int c = 1; c <= 400 && dc == 0; c++) begin
      if (c > 1) step();
      if (b_sum_ld) nld++;
      if (b_mem_rd) nrd++;
      if (int'(b_addr) > amax) amax = int'(b_addr);
      if (b_done) dc = c;
    end
    n_checks++;
    if (dc !== 260) $display("FAIL big_latency: got %0d expected 260", dc);
    else n_pass++;
    n_checks++;
    if (nld !== 256 || nrd !== 256)
      $display("FAIL big_counts: got ld=%0d rd=%0d expected 256/256", nld, nrd);
    else n_pass++;
    n_checks++;
    if (amax !== 255) $display("FAIL big_addr_max: got %0d expected 255", amax);
    else n_pass++;
  endtask

`ifdef SAD_CTRL_ABORT_EN
  task automatic test_abort();
    int bad = 0;
    int guard = 0;
    go = 1'b1; step(); go = 1'b0;
    step(); step();
    n_checks++;
    if (addr !== 8'd1) $display("FAIL abort_addr: got %0d expected 1", addr);
    else n_pass++;
    abort = 1'b1; step(); abort = 1'b0;
    n_checks++;
    if ({aborted, busy, mem_rd, sum_ld} !== 4'b1000)
      $display("FAIL abort_take: got %b expected 1000", {aborted, busy, mem_rd, sum_ld});
    else n_pass++;
    step();
    n_checks++;
    if (aborted !== 1'b0) $display("FAIL abort_pulse: got %b expected 0", aborted);
    else n_pass++;
    for (int c = 0; c < 10; c++) begin
      step();
      if (sadreg_ld || done || aborted) bad++;
    end
    n_checks++;
    if (bad !== 0) $display("FAIL abort_quiet: got %0d active cycles expected 0", bad);
    else n_pass++;
    go = 1'b1; step(); go = 1'b0;
    while (!sadreg_ld && guard < 12) begin
      step();
      guard++;
    end
    abort = 1'b1;
    step();
    n_checks++;
    if ({done, aborted} !== 2'b10)
      $display("FAIL abort_in_store: got %b expected 10", {done, aborted});
    else n_pass++;
    step();
    abort = 1'b0;
    n_checks++;
    if ({aborted, busy} !== 2'b00)
      $display("FAIL abort_in_done: got %b expected 00", {aborted, busy});
    else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    step(); step();
    test_go_during_read();
    test_mid_reset();
    step(); step();
    test_default_size();
`ifdef SAD_CTRL_ABORT_EN
    step(); step();
    test_abort();
`endif
    n_checks++;
    if (viol !== 0) $display("FAIL strobe_invariant: got %0d violations expected 0", viol);
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
